energy_telemetry_tx: RTL
========================

Name: energy_telemetry_tx

Overview:
Serial telemetry transmitter for the renewable energy converter. It takes one sample per handshake: the input-voltage code driven on ui_in and the converter's current duty code. It frames each sample as a 4-byte packet and shifts it out as 8N1 UART on a single pin. This is the outbound data link that carries the converter's measurements off-chip, to the host side that reads them.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range is 2 or more.
SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
sample_valid  input  1  voltage and duty hold a sample to send.
sample_ready  output  1  block can accept a sample.
voltage  input  8  input-voltage code, same encoding as ui_in.
duty  input  8  converter duty code.
tx  output  1  UART serial line; idle level is 1.
busy  output  1  a packet is in flight.
frame_done  output  1  one-cycle pulse at the end of a packet.

Behaviour:
- Reset (rst=1 sampled on a clk edge): next cycle tx=1, busy=0, frame_done=0, sample_ready=1, all counters=0, state=IDLE.
- Reset mid-packet aborts immediately. tx returns to 1 on the next cycle, the partial packet is discarded and is never resumed.
- Handshake: a sample is accepted on a cycle where sample_valid && sample_ready.
  - sample_ready = (state==IDLE) && !rst.
  - voltage and duty are latched on acceptance; later input changes are ignored.
- Packet bytes, in order: SYNC_BYTE, voltage, duty, checksum.
  - checksum = (SYNC_BYTE + voltage + duty) mod 256, 8-bit wrap, carry discarded.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - Bytes are sent back-to-back with no idle gap: byte n's stop bit is followed directly by byte n+1's start bit.
- Latency: tx drives the first start bit in the cycle after acceptance. Total packet = 40*CLKS_PER_BIT cycles.
- State machine:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if byte_idx<3 (byte_idx increments).
  - STOP -> IDLE if byte_idx==3.
- Counters: bit-timer counts 0..CLKS_PER_BIT-1 then wraps; bit_idx counts 0..7; byte_idx counts 0..3.
- busy = (state!=IDLE).
- frame_done asserts for one cycle, in the last cycle of the final stop bit. On the following cycle state=IDLE and sample_ready=1.
- Back-to-back: if sample_valid is held high, the next packet is accepted on the first IDLE cycle. The line therefore holds exactly 1 idle-high cycle between packets.
- sample_valid while busy: no effect, no queuing; the source must hold the sample until ready.
- tx is registered (glitch-free) and is never X after reset.

Decomposition:
- Package energy_telemetry_pkg:
  - state enum: IDLE, START, DATA, STOP;
  - FRAME_BYTES=4;
  - default SYNC_BYTE;
  - checksum function (8-bit wrap sum).
- One sub-module, uart_byte_tx:
  - serializes a single byte using the start/8-data/stop format;
  - ports: clk, rst, load, byte_in, tx, byte_done;
  - parameterised by CLKS_PER_BIT.
- Top level owns the handshake, byte_idx, packet mux and frame_done.

Test Plan:
- All tests use CLKS_PER_BIT=4.
- Reset: rst=1 for 2 cycles, then 0 -> tx=1, busy=0, sample_ready=1, frame_done=0 from the first post-reset cycle.
- Single packet: voltage=8'd25 (0x19), duty=8'd45 (0x2D), valid for 1 cycle.
  - Decoded tx bytes must be A5, 19, 2D, EB.
  - frame_done pulses exactly 160 cycles after acceptance.
  - tx falls 1 cycle after acceptance.
- Checksum wrap: voltage=0xFF, duty=0xFF -> bytes A5, FF, FF, A3.
- Busy ignore: during a packet, change voltage to 0x00 and pulse sample_valid mid-frame.
  - The transmitted bytes are unchanged.
  - Exactly one packet is sent.
- Back-to-back: sample_valid held high with (0x19,0x2D), then (0x2D,0x19).
  - The two packets are separated by exactly 1 idle-high cycle.
  - Second checksum = EB.
- Reset mid-frame: assert rst during the DATA bits of byte 2.
  - tx=1 the next cycle, busy=0.
  - A fresh packet accepted afterwards starts with SYNC_BYTE A5.

Source files
------------

// File: rtl/energy_telemetry_pkg.sv
// Shared types and constants for the energy telemetry UART transmitter.
package energy_telemetry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned FRAME_BYTES = 4;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] checksum(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Serializes one byte as 8N1: start bit, 8 data bits LSB first, stop bit.
// A load in the last stop-bit cycle chains the next byte with no idle gap.
module uart_byte_tx
  import energy_telemetry_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  state_t        r_state, w_state_n;
  logic [TW-1:0] r_timer, w_timer_n;
  logic [2:0]    r_bit_idx, w_bit_idx_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_tx, w_tx_n;
  logic          w_bit_end;

  assign w_bit_end = (r_timer == LAST_TICK);
  assign tx        = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_timer   <= w_timer_n;
      r_bit_idx <= w_bit_idx_n;
      r_shift   <= w_shift_n;
      r_tx      <= w_tx_n;
    end
  end

  // tx is registered, so the next line level is decided alongside the next state.
  always_comb begin
    w_state_n   = r_state;
    w_timer_n   = r_timer;
    w_bit_idx_n = r_bit_idx;
    w_shift_n   = r_shift;
    w_tx_n      = r_tx;
    byte_done   = 1'b0;
    case (r_state)
      IDLE: w_tx_n = 1'b1;
      START: begin
        if (w_bit_end) begin
          w_timer_n   = '0;
          w_bit_idx_n = '0;
          w_state_n   = DATA;
          w_tx_n      = r_shift[0];
        end else begin
          w_timer_n = r_timer + TW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_timer_n = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_n = STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_idx_n = r_bit_idx + 3'd1;
            w_shift_n   = {1'b0, r_shift[7:1]};
            w_tx_n      = r_shift[1];
          end
        end else begin
          w_timer_n = r_timer + TW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          byte_done = 1'b1;
          w_timer_n = '0;
          w_state_n = IDLE;
          w_tx_n    = 1'b1;
        end else begin
          w_timer_n = r_timer + TW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
    if (load) begin
      w_state_n   = START;
      w_timer_n   = '0;
      w_bit_idx_n = '0;
      w_shift_n   = byte_in;
      w_tx_n      = 1'b0;
    end
  end

endmodule

// File: rtl/energy_telemetry_tx.sv
// Telemetry packet transmitter: latches one (voltage, duty) sample per handshake
// and sends SYNC, voltage, duty, checksum as back-to-back 8N1 bytes.
module energy_telemetry_tx
  import energy_telemetry_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [7:0] voltage,
  input  logic [7:0] duty,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  logic       r_busy;
  logic [1:0] r_byte_idx;
  logic [7:0] r_voltage, r_duty;
  logic       w_accept, w_byte_done, w_last_byte, w_load;
  logic [1:0] w_next_idx;
  logic [7:0] w_byte_sel;

  assign sample_ready = !r_busy && !rst;
  assign busy         = r_busy;
  assign w_accept     = sample_valid && sample_ready;
  assign w_last_byte  = w_byte_done && (r_byte_idx == LAST_IDX);
  assign frame_done   = w_last_byte && !rst;
  assign w_next_idx   = r_byte_idx + 2'd1;
  // The next byte is loaded on the stop-bit's final cycle so no idle gap appears.
  assign w_load       = w_accept || (w_byte_done && !w_last_byte);

  always_comb begin
    w_byte_sel = SYNC_BYTE;
    if (!w_accept) begin
      case (w_next_idx)
        2'd1:    w_byte_sel = r_voltage;
        2'd2:    w_byte_sel = r_duty;
        2'd3:    w_byte_sel = checksum(SYNC_BYTE, r_voltage, r_duty);
        default: w_byte_sel = SYNC_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_byte_idx <= '0;
      r_voltage  <= '0;
      r_duty     <= '0;
    end else if (w_accept) begin
      r_busy     <= 1'b1;
      r_byte_idx <= '0;
      r_voltage  <= voltage;
      r_duty     <= duty;
    end else if (w_byte_done) begin
      if (w_last_byte) begin
        r_busy     <= 1'b0;
        r_byte_idx <= '0;
      end else begin
        r_byte_idx <= w_next_idx;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .byte_in  (w_byte_sel),
    .tx       (tx),
    .byte_done(w_byte_done)
  );

endmodule
